// File: rtl/teclado_detector.sv
// teclado_detector: 4x4 active-low matrix keypad decoder.
//
// Row and column lines pass through 2-flop synchronizers. A sample is
// accepted as a key only when exactly one row and exactly one column are
// low; the code must then stay stable for DEBOUNCE_CYCLES samples before
// it is latched. Release is debounced in the same way before another key
// is considered, so there is no rollover.
//
// Optional feature macro: TECLADO_STROBE_EN adds key_strobe, a one-cycle
// pulse on the edge after key_pressed is loaded.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous reset, active low
//   row[3:0]     keypad rows, active low, bit 0 = top row
//   column[3:0]  keypad columns, active low, bit 0 = left column
//   key_pressed  code of the last accepted key, registered
//   key_strobe   (TECLADO_STROBE_EN only) one-cycle acceptance pulse
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | no key down; waiting for a valid single-key sample
// DEBOUNCE | candidate captured; counting consecutive matching samples
// PRESSED  | key accepted; waiting for all lines to go idle
// RELEASE  | lines idle; counting consecutive idle samples
module teclado_detector #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    input  logic [3:0] column,
`ifdef TECLADO_STROBE_EN
    output logic       key_strobe,
`endif
    output logic [3:0] key_pressed
);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [3:0]       row_meta_q, row_meta_d, row_s_q, row_s_d;
    logic [3:0]       col_meta_q, col_meta_d, col_s_q, col_s_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]       cand_q, cand_d;
    logic [3:0]       key_q, key_d;

    logic       row_one, col_one, sample_valid, sample_idle;
    logic [1:0] row_idx, col_idx;
    logic [3:0] sample_code;

    // Returns the index of the single low bit; ok is 0 when the pattern
    // does not have exactly one low bit.
    function automatic logic [2:0] one_cold(input logic [3:0] v);
        logic [2:0] r;
        unique case (v)
            4'b1110: r = 3'b100;
            4'b1101: r = 3'b101;
            4'b1011: r = 3'b110;
            4'b0111: r = 3'b111;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        unique case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    always_comb begin
        row_meta_d = row;
        row_s_d    = row_meta_q;
        col_meta_d = column;
        col_s_d    = col_meta_q;

        {row_one, row_idx} = one_cold(row_s_q);
        {col_one, col_idx} = one_cold(col_s_q);
        sample_valid = row_one && col_one;
        sample_idle  = (row_s_q == 4'b1111) && (col_s_q == 4'b1111);
        sample_code  = key_code(row_idx, col_idx);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        key_d   = key_q;
        cnt_inc = cnt_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (sample_valid) begin
                    cand_d  = sample_code;
                    cnt_d   = CNT_W'(1);
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (sample_valid && (sample_code == cand_q)) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        key_d   = cand_q;
                        state_d = PRESSED;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            PRESSED: begin
                if (sample_idle) begin
                    cnt_d   = CNT_W'(1);
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (sample_idle) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d   = '0;
                    state_d = PRESSED;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            row_meta_q <= 4'b1111;
            row_s_q    <= 4'b1111;
            col_meta_q <= 4'b1111;
            col_s_q    <= 4'b1111;
            state_q    <= IDLE;
            cnt_q      <= '0;
            cand_q     <= 4'h0;
            key_q      <= 4'h0;
        end else begin
            row_meta_q <= row_meta_d;
            row_s_q    <= row_s_d;
            col_meta_q <= col_meta_d;
            col_s_q    <= col_s_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            key_q      <= key_d;
        end
    end

    assign key_pressed = key_q;

`ifdef TECLADO_STROBE_EN
    // loaded_q marks the cycle key_pressed was loaded; the strobe follows
    // one edge later so consumers see the new code already stable.
    logic loaded_q, loaded_d, key_strobe_q, key_strobe_d;

    always_comb begin
        loaded_d     = (state_q == DEBOUNCE) && (state_d == PRESSED);
        key_strobe_d = loaded_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            loaded_q     <= 1'b0;
            key_strobe_q <= 1'b0;
        end else begin
            loaded_q     <= loaded_d;
            key_strobe_q <= key_strobe_d;
        end
    end

    assign key_strobe = key_strobe_q;
`endif

endmodule

// File: tb/tb_teclado_detector.sv
module tb_teclado_detector;

    localparam int D = 16;

    // Key map by row*4 + column.
    localparam logic [3:0] KEYMAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] row = 4'b1111;
    logic [3:0] column = 4'b1111;
    logic [3:0] key_pressed;
`ifdef TECLADO_STROBE_EN
    logic       key_strobe;
`endif

    int checks = 0;
    int failures = 0;

    teclado_detector #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .row(row),
        .column(column),
`ifdef TECLADO_STROBE_EN
        .key_strobe(key_strobe),
`endif
        .key_pressed(key_pressed)
    );

    always #5 clk = ~clk;

    // Reference model: the line values seen two edges late, a run length of
    // identical valid codes while free, and a run length of idle samples
    // while a key is held.
    logic [7:0] pipe1 = 8'hFF;
    logic [7:0] pipe2 = 8'hFF;
    logic [3:0] m_key = 4'h0;
    logic [3:0] m_code = 4'h0;
    bit         m_held = 1'b0;
    int         m_run = 0;

    function automatic int line_idx(input logic [3:0] v);
        if ($countones(v) != 3) return -1;
        for (int i = 0; i < 4; i++) if (!v[i]) return i;
        return -1;
    endfunction

    task automatic model_step();
        logic [7:0] s;
        int r, c;
        bit valid, idle;
        logic [3:0] code;
        s = pipe2;
        if (!rst) begin
            pipe1 = 8'hFF; pipe2 = 8'hFF;
            m_key = 4'h0; m_held = 1'b0; m_run = 0;
        end else begin
            pipe2 = pipe1;
            pipe1 = {row, column};
            r = line_idx(s[7:4]);
            c = line_idx(s[3:0]);
            valid = (r >= 0) && (c >= 0);
            idle  = (s == 8'hFF);
            code  = valid ? KEYMAP[r*4 + c] : 4'h0;
            if (!m_held) begin
                if (m_run == 0) begin
                    if (valid) begin m_code = code; m_run = 1; end
                end else if (valid && code == m_code) begin
                    m_run = m_run + 1;
                    if (m_run == D) begin m_key = m_code; m_held = 1'b1; m_run = 0; end
                end else begin
                    m_run = 0;  // the breaking sample is discarded
                end
            end else begin
                if (idle) begin
                    m_run = m_run + 1;
                    if (m_run == D) begin m_held = 1'b0; m_run = 0; end
                end else begin
                    m_run = 0;
                end
            end
        end
    endtask

    always @(posedge clk) model_step();

    task automatic chk(input string tag, input logic [3:0] exp);
        checks++;
        assert (key_pressed === exp) else begin
            failures++;
            $error("FAIL %s: key_pressed=%h expected=%h", tag, key_pressed, exp);
        end
    endtask

    task automatic hold_model(input int n, input string tag);
        repeat (n) begin
            @(negedge clk);
            chk(tag, m_key);
        end
    endtask

    // Called right after inputs change at a negedge: key_pressed must keep
    // old_v for 17 edges and show new_v after the 18th.
    task automatic latency(input string tag, input logic [3:0] old_v, input logic [3:0] new_v);
        for (int i = 1; i <= D + 1; i++) begin
            @(posedge clk); #1;
            chk({tag, "_wait"}, old_v);
        end
        @(posedge clk); #1;
        chk({tag, "_hit"}, new_v);
        @(negedge clk);
    endtask

    task automatic press(input logic [3:0] r, input logic [3:0] c, input int n,
                         input int rel, input string tag);
        row = r; column = c;
        hold_model(n, tag);
        row = 4'b1111; column = 4'b1111;
        hold_model(rel, {tag, "_rel"});
    endtask

    initial begin
        // Reset
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("reset_low", 4'h0);
        rst = 1'b1;
        hold_model(5, "reset_idle");
        chk("reset_val", 4'h0);

        // Key "1" with exact latency
        row = 4'b1110; column = 4'b1110;
        latency("key1", 4'h0, 4'h1);
        hold_model(8, "key1_hold");
        row = 4'b1111; column = 4'b1111;
        hold_model(27, "key1_rel");
        chk("key1_after_rel", 4'h1);

        // Row 0 sweep
        press(4'b1110, 4'b1101, 27, 27, "sweep2");
        chk("sweep2_val", 4'h2);
        press(4'b1110, 4'b1011, 27, 27, "sweep3");
        chk("sweep3_val", 4'h3);
        press(4'b1110, 4'b0111, 27, 27, "sweepA");
        chk("sweepA_val", 4'hA);

        // Glitch then genuine "5"
        press(4'b1101, 4'b1101, 10, 27, "glitch5");
        chk("glitch5_val", 4'hA);
        press(4'b1101, 4'b1101, 20, 27, "key5");
        chk("key5_val", 4'h5);

        // Two columns on one row: invalid
        press(4'b1110, 4'b1100, 40, 27, "invalid");
        chk("invalid_val", 4'h5);

        // No rollover: hold "1", slide straight onto "2"
        row = 4'b1110; column = 4'b1110;
        hold_model(27, "roll_first");
        chk("roll_first_val", 4'h1);
        column = 4'b1101;
        hold_model(30, "roll_second");
        chk("roll_ignored", 4'h1);
        row = 4'b1111; column = 4'b1111;
        hold_model(27, "roll_rel");
        press(4'b1110, 4'b1101, 27, 27, "roll_repress");
        chk("roll_repress_val", 4'h2);

        // Reset while "9" is held, then re-acceptance
        row = 4'b1011; column = 4'b1011;
        hold_model(25, "key9");
        chk("key9_val", 4'h9);
        rst = 1'b0;
        @(negedge clk);
        chk("midreset", 4'h0);
        hold_model(2, "midreset_hold");
        rst = 1'b1;
        latency("key9_again", 4'h0, 4'h9);
        row = 4'b1111; column = 4'b1111;
        hold_model(27, "key9_rel");

        // Randomized traffic against the model
        for (int it = 0; it < 250; it++) begin
            int k;
            k = $urandom_range(0, 99);
            if (k < 60) begin
                row    = ~(4'b0001 << $urandom_range(0, 3));
                column = ~(4'b0001 << $urandom_range(0, 3));
            end else if (k < 75) begin
                row = 4'b1111; column = 4'b1111;
            end else begin
                row    = 4'($urandom);
                column = 4'($urandom);
            end
            hold_model($urandom_range(1, 40), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
